// File: rtl/priority_encoder_with_mask.sv
// Masked priority encoder. The request vector is reduced to the index of its
// winning unmasked bit, and that index is registered together with a valid flag.
module priority_encoder_with_mask #(
   parameter int WIDTH     = 16,
   parameter int OUT_WIDTH = $clog2(WIDTH),
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     data_in,
   input  logic [WIDTH-1:0]     mask,
   output logic [OUT_WIDTH-1:0] encoded_out,
   output logic                 valid
);

   // Reject bad parameter combinations at elaboration time, before any hardware is built.
   if (WIDTH < 2 || WIDTH > 1024) begin : g_bad_width
      $error("priority_encoder_with_mask: WIDTH must be in 2..1024");
   end
   if (OUT_WIDTH != $clog2(WIDTH)) begin : g_bad_out_width
      $error("priority_encoder_with_mask: OUT_WIDTH must equal $clog2(WIDTH)");
   end

   logic [WIDTH-1:0]     eff;
   logic [OUT_WIDTH-1:0] encoded_d, encoded_q;
   logic                 valid_d, valid_q;

   assign eff = data_in & ~mask;

   // The scan runs toward the priority end, so the last set bit it meets wins.
   // Only real bit positions are scanned, so the index stays at or below WIDTH-1.
   always_comb begin
      encoded_d = '0;
      valid_d   = |eff;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (eff[i]) encoded_d = OUT_WIDTH'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (eff[i]) encoded_d = OUT_WIDTH'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         encoded_q <= '0;
         valid_q   <= 1'b0;
      end else begin
         encoded_q <= encoded_d;
         valid_q   <= valid_d;
      end
   end

   assign encoded_out = encoded_q;
   assign valid       = valid_q;

endmodule

// File: tb/tb_priority_encoder_with_mask.sv
// Directed bench for priority_encoder_with_mask: MSB-first and LSB-first
// instances at WIDTH=16, plus a WIDTH=5 instance for the non-power-of-two case.
module tb_priority_encoder_with_mask;

   logic        clk = 1'b0;
   logic        rst;

   logic [15:0] d_m, m_m;
   logic [3:0]  e_m;
   logic        v_m;

   logic [15:0] d_l, m_l;
   logic [3:0]  e_l;
   logic        v_l;

   logic [4:0]  d_5, m_5;
   logic [2:0]  e_5;
   logic        v_5;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   priority_encoder_with_mask #(.WIDTH(16), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .data_in(d_m), .mask(m_m),
      .encoded_out(e_m), .valid(v_m));

   priority_encoder_with_mask #(.WIDTH(16), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .data_in(d_l), .mask(m_l),
      .encoded_out(e_l), .valid(v_l));

   priority_encoder_with_mask #(.WIDTH(5), .MSB_FIRST(1'b1)) u_w5 (
      .clk(clk), .rst(rst), .data_in(d_5), .mask(m_5),
      .encoded_out(e_5), .valid(v_5));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs_e, input logic obs_v,
                        input logic [15:0] exp_e, input logic exp_v);
      n_vec++;
      assert (obs_e === exp_e) else begin
         n_err++;
         $error("FAIL %s encoded_out observed=%0d expected=%0d", tag, obs_e, exp_e);
      end
      n_vec++;
      assert (obs_v === exp_v) else begin
         n_err++;
         $error("FAIL %s valid observed=%0b expected=%0b", tag, obs_v, exp_v);
      end
   endtask

   // Reference: walk from the priority end until the first set bit is found.
   function automatic void ref_enc(input logic [15:0] d, input logic [15:0] m, input int w,
                                   input bit msb_first, output logic [15:0] idx,
                                   output logic vld);
      logic [15:0] eff;
      int pos;
      int remaining;
      eff = d & ~m;
      idx = '0;
      vld = 1'b0;
      pos = msb_first ? w - 1 : 0;
      remaining = w;
      while (remaining > 0 && !vld) begin
         if (eff[pos]) begin
            vld = 1'b1;
            idx = 16'(pos);
         end
         pos = msb_first ? pos - 1 : pos + 1;
         remaining--;
      end
   endfunction

   initial begin
      logic [15:0] xe_m, xe_l, xe_5;
      logic        xv_m, xv_l, xv_5;

      rst = 1'b1;
      d_m = 16'hFFFF; m_m = 16'h0000;
      d_l = 16'hFFFF; m_l = 16'h0000;
      d_5 = 5'h1F;    m_5 = 5'h00;

      step();
      check("rst1_msb", e_m, v_m, 0, 0);
      check("rst1_lsb", e_l, v_l, 0, 0);
      check("rst1_w5",  e_5, v_5, 0, 0);
      step();
      check("rst2_msb", e_m, v_m, 0, 0);
      check("rst2_lsb", e_l, v_l, 0, 0);
      check("rst2_w5",  e_5, v_5, 0, 0);

      rst = 1'b0;
      step();
      check("rel_msb", e_m, v_m, 15, 1);
      check("rel_lsb", e_l, v_l, 0, 1);
      check("rel_w5",  e_5, v_5, 4, 1);

      d_m = 16'h22CF; m_m = 16'h008C;
      d_l = 16'h22CF; m_l = 16'h008C;
      d_5 = 5'b10110; m_5 = 5'b10000;
      step();
      check("eff2243_msb", e_m, v_m, 13, 1);
      check("eff2243_lsb", e_l, v_l, 0, 1);
      check("w5_10110",    e_5, v_5, 2, 1);

      d_m = 16'hE2CF; m_m = 16'h0E8C;
      d_l = 16'h2240; m_l = 16'h0000;
      d_5 = 5'b11111; m_5 = 5'b11111;
      step();
      check("effE043_msb", e_m, v_m, 15, 1);
      check("d2240_lsb",   e_l, v_l, 6, 1);
      check("w5_allmask",  e_5, v_5, 0, 0);

      d_m = 16'h0001; m_m = 16'h008C;
      d_l = 16'h00F0; m_l = 16'h00F0;
      d_5 = 5'b00001; m_5 = 5'b00000;
      step();
      check("bit0_msb",     e_m, v_m, 0, 1);
      check("allmask_lsb",  e_l, v_l, 0, 0);
      check("w5_bit0",      e_5, v_5, 0, 1);

      d_m = 16'h02CF; m_m = 16'h008C;
      d_l = 16'h8000; m_l = 16'h0000;
      d_5 = 5'b10000; m_5 = 5'b00000;
      step();
      check("eff0243_msb", e_m, v_m, 9, 1);
      check("bit15_lsb",   e_l, v_l, 15, 1);
      check("w5_bit4",     e_5, v_5, 4, 1);

      d_m = 16'h0203; m_m = 16'h008E;
      step();
      check("eff0201_msb", e_m, v_m, 9, 1);

      d_m = 16'h008C; m_m = 16'h008C;
      step();
      check("maskedzero_msb", e_m, v_m, 0, 0);

      d_m = 16'h0000; m_m = 16'h0000;
      step();
      check("zero_msb", e_m, v_m, 0, 0);

      d_m = 16'hFFFF; m_m = 16'hFFFF;
      step();
      check("allmask_msb", e_m, v_m, 0, 0);

      // Reset asserted mid-stream with live requests, then released.
      d_m = 16'h0410; m_m = 16'h0000;
      d_l = 16'h0410; m_l = 16'h0000;
      d_5 = 5'b01000; m_5 = 5'b00000;
      rst = 1'b1;
      step();
      check("midrst_msb", e_m, v_m, 0, 0);
      check("midrst_lsb", e_l, v_l, 0, 0);
      check("midrst_w5",  e_5, v_5, 0, 0);
      rst = 1'b0;
      step();
      check("post_msb", e_m, v_m, 10, 1);
      check("post_lsb", e_l, v_l, 4, 1);
      check("post_w5",  e_5, v_5, 3, 1);

      // Back-to-back vectors: new inputs every cycle, result checked one edge later.
      for (int k = 0; k < 200; k++) begin
         d_m = 16'($urandom_range(0, 65535));
         m_m = 16'($urandom_range(0, 65535));
         d_l = 16'($urandom_range(0, 65535));
         m_l = (k % 4 == 0) ? 16'h0000 : 16'($urandom_range(0, 65535));
         d_5 = 5'($urandom_range(0, 31));
         m_5 = 5'($urandom_range(0, 31));
         ref_enc(d_m, m_m, 16, 1'b1, xe_m, xv_m);
         ref_enc(d_l, m_l, 16, 1'b0, xe_l, xv_l);
         ref_enc({11'd0, d_5}, {11'd0, m_5}, 5, 1'b1, xe_5, xv_5);
         step();
         check("rand_msb", e_m, v_m, xe_m, xv_m);
         check("rand_lsb", e_l, v_l, xe_l, xv_l);
         check("rand_w5",  e_5, v_5, xe_5, xv_5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/priority_encoder_with_mask.md
Name: priority_encoder_with_mask

Overview:
- Parameterised masked priority encoder with a registered output.
- Each cycle it:
  - clears the masked bits of a WIDTH-bit request vector;
  - finds the highest-priority remaining set bit;
  - registers that bit's binary index and a valid flag.
- Used as an arbitration/selection front end wherever a request vector must be reduced to one index with selected requesters disabled.

Parameters:
- WIDTH, 16, number of request bits; legal range 2..1024; need not be a power of two.
- OUT_WIDTH, $clog2(WIDTH), width of encoded index; derived, must not be overridden inconsistently.
- MSB_FIRST, 1, 1 = highest index has priority; 0 = lowest index has priority.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  request vector; bit i set = requester i active.
- mask  input  WIDTH  mask vector; bit i set = requester i disabled (ignored).
- encoded_out  output  OUT_WIDTH  registered binary index of winning request bit.
- valid  output  1  registered; 1 when at least one unmasked request bit was set.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset: on a rising clk edge with rst=1, encoded_out <= 0 and valid <= 0. rst overrides all inputs in that cycle.
- Effective vector: eff = data_in & ~mask, bitwise. A mask bit of 1 always removes that request, whatever data_in holds.
- Winner selection with MSB_FIRST=1: index of the highest set bit of eff.
- Winner selection with MSB_FIRST=0: index of the lowest set bit of eff.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N; results visible after edge N. No internal pipeline beyond this single register stage.
- Throughput: a new input is accepted every cycle. No handshake, no stall.
- eff == 0, including all-masked or data_in == 0: valid <= 0 and encoded_out <= 0. Never hold the previous value.
- eff != 0: valid <= 1 and encoded_out <= winner index. Index is zero-extended to OUT_WIDTH.
- Single-bit eff: encoded_out equals that bit's position; priority order is irrelevant.
- Non-power-of-two WIDTH: encoded_out never exceeds WIDTH-1.
- X/undefined bits: no defined behaviour is required.
- Combinational logic: pure function of data_in and mask. No latches; no dependence on previous outputs.
- Reset deasserted mid-stream: the first non-reset edge registers the current inputs normally.

Test Plan:
- rst=1 for 2 cycles with data_in=16'hFFFF, mask=0 -> encoded_out=0, valid=0. Release rst -> next edge gives encoded_out=15, valid=1.
- data_in=16'h22CF, mask=16'h008C (eff=16'h2243) -> encoded_out=13, valid=1. Then data_in=16'hE2CF, mask=16'h0E8C (eff=16'hE043) -> encoded_out=15, valid=1.
- data_in=16'h0001, mask=16'h008C -> encoded_out=0, valid=1. Then data_in=16'h02CF, mask=16'h008C -> encoded_out=9, valid=1. Then data_in=16'h0203, mask=16'h008E -> encoded_out=9, valid=1.
- Masked-to-zero case: data_in=16'h008C, mask=16'h008C -> encoded_out=0, valid=0. Next cycle data_in=0, mask=0 -> encoded_out=0, valid=0.
- MSB_FIRST=0 instance, data_in=16'h22CF, mask=16'h008C -> encoded_out=0, valid=1. With data_in=16'h2240, mask=0 -> encoded_out=6, valid=1.
- WIDTH=5 (OUT_WIDTH=3): data_in=5'b10110, mask=5'b10000 -> encoded_out=2, valid=1.
- Back-to-back random vectors against the reference model, checking the 1-cycle latency every cycle.
